// File: rtl/counted_register_7bits.sv
// Sample-and-hold of a running count: an enabled up-counter whose value feeds
// a load-selected holding register. Both outputs come straight from flops.

module counter_7bit_enable #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             count_enb,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_one;

  assign w_one = {{(WIDTH-1){1'b0}}, 1'b1};

  // Count register: clear on reset, wrap naturally on overflow (carry dropped).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= {WIDTH{1'b0}};
    end else if (count_enb) begin
      r_count <= r_count + w_one;
    end else begin
      r_count <= r_count;
    end
  end

  assign count = r_count;

endmodule

module register_7bits #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             select,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  // Holding register: loads d when selected, otherwise keeps its contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= {WIDTH{1'b0}};
    end else if (select) begin
      r_q <= d;
    end else begin
      r_q <= r_q;
    end
  end

  assign q = r_q;

endmodule

module counted_register_7bits #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             count_enb,
  input  logic             select,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] q
);

  // The register samples the pre-increment count, so q lags count by one edge.
  logic [WIDTH-1:0] w_count;

  counter_7bit_enable #(.WIDTH(WIDTH)) u_counter (
    .clk       (clk),
    .reset     (reset),
    .count_enb (count_enb),
    .count     (w_count)
  );

  register_7bits #(.WIDTH(WIDTH)) u_register (
    .clk    (clk),
    .reset  (reset),
    .select (select),
    .d      (w_count),
    .q      (q)
  );

  assign count = w_count;

endmodule

// File: tb/tb_counted_register_7bits.sv
// Self-checking bench: directed phases plus random traffic, compared each cycle
// against an arithmetic model of the count and the held sample.

module tb_counted_register_7bits;

  logic       clk;
  logic       reset;
  logic       count_enb;
  logic       select;
  logic [6:0] count;
  logic [6:0] q;

  int n_cmp;
  int n_bad;
  int m_cnt;
  int m_q;

  counted_register_7bits dut (
    .clk       (clk),
    .reset     (reset),
    .count_enb (count_enb),
    .select    (select),
    .count     (count),
    .q         (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model, then check both outputs.
  task automatic step(input logic rst, input logic en, input logic sel);
    reset     = rst;
    count_enb = en;
    select    = sel;
    @(posedge clk);
    if (rst) begin
      m_cnt = 0;
      m_q   = 0;
    end else begin
      if (sel) m_q = m_cnt;
      if (en)  m_cnt = (m_cnt + 1) % 128;
    end
    #1;
    check_val("count", int'(count), m_cnt);
    check_val("q", int'(q), m_q);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    m_cnt = 0;
    m_q   = 0;
    reset = 1'b1;
    count_enb = 1'b0;
    select = 1'b0;

    // Reset held with enable and select asserted.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b1);
      check_val("rst_count", int'(count), 0);
      check_val("rst_q", int'(q), 0);
    end

    // Count through the wrap with select low.
    for (int i = 1; i <= 130; i++) begin
      step(1'b0, 1'b1, 1'b0);
      check_val("wrap_seq", int'(count), i % 128);
    end
    check_val("wrap_end", int'(count), 2);
    check_val("wrap_q", int'(q), 0);

    // Enable hold at 5.
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0);
      check_val("hold5", int'(count), 5);
    end
    step(1'b0, 1'b1, 1'b0);
    check_val("resume6", int'(count), 6);

    // Select toggling every 8 clocks.
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 1'b1, ((i / 8) % 2) == 1);
      if (((i / 8) % 2) == 1)
        check_val("track", int'(q), (int'(count) + 127) % 128);
      if (i == 15)
        check_val("freeze15", int'(q), 15);
      if (i >= 16 && i < 24)
        check_val("frozen", int'(q), 15);
    end

    // Mid-run reset at count=42, q=41.
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 42; i++) step(1'b0, 1'b1, 1'b1);
    check_val("pre_rst_count", int'(count), 42);
    check_val("pre_rst_q", int'(q), 41);
    step(1'b1, 1'b1, 1'b1);
    check_val("mid_rst_count", int'(count), 0);
    check_val("mid_rst_q", int'(q), 0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, i >= 3);
    check_val("after_rst", int'(count), 6);
    check_val("after_rst_q", int'(q), 5);

    // Capture across the 127 -> 0 wrap.
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 126; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    check_val("cap126", int'(q), 126);
    step(1'b0, 1'b1, 1'b1);
    check_val("cap127", int'(q), 127);
    step(1'b0, 1'b1, 1'b1);
    check_val("cap0", int'(q), 0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 19) == 0), $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
